line_pixel_writer: RTL and testbench

- Downstream stage of the line rasteriser. It consumes the per-cycle X/Y pixel stream and the finish strobe, and buffers pixels in a small FIFO.
- It writes each pixel into the 256x256 framebuffer over a single-word write/ack memory port, at address {Y,X}.
- It also provides a full-screen clear sweep.
- It raises a one-cycle DONE pulse once every pixel of a finished line, or the whole clear sweep, is committed to memory.

---
 rtl/line_pixel_writer.sv | 147 ++++++++++++++
 tb/tb_line_pixel_writer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/line_pixel_writer.sv
// Pixel sink for the line rasteriser: queues {Y,X,colour} in a small FIFO and
// commits each entry to a 256x256 framebuffer over a write/ack port; also runs a full-screen clear.
module line_pixel_writer #(
  parameter int                 FIFO_DEPTH  = 8,
  parameter int                 COLOR_W     = 8,
  parameter logic [COLOR_W-1:0] CLEAR_COLOR = '0
) (
  input  logic               ACLK,
  input  logic               ARESETn,
  input  logic               EN,
  input  logic               PIX_VALID,
  input  logic [7:0]         PIX_X,
  input  logic [7:0]         PIX_Y,
  input  logic               LINE_FINISH,
  input  logic [COLOR_W-1:0] COLOR,
  output logic               PIX_READY,
  input  logic               CLEAR,
  output logic [15:0]        MEM_ADDR,
  output logic [COLOR_W-1:0] MEM_DATA,
  output logic               MEM_WE,
  input  logic               MEM_ACK,
  output logic               BUSY,
  output logic               DONE,
  output logic               OVF
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = 16 + COLOR_W;
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_CLEAR} state_t;

  logic [EW-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  state_t        state;
  logic          finish_d;
  logic          pending;
  logic          clr_first;

  logic          push;
  logic          pop;
  logic          retire;
  logic          clear_go;
  logic          finish_rise;
  logic          done_line;
  logic          sweep_last;
  logic          sweep_issue;
  logic [PW:0]   count_next;
  logic          we_next;
  state_t        state_next;
  logic          ready_next;

  always_comb begin
    push        = PIX_VALID & PIX_READY;
    retire      = MEM_WE & MEM_ACK;
    pop         = (state != ST_CLEAR) & EN & (count != '0) & (!MEM_WE | MEM_ACK);
    finish_rise = LINE_FINISH & !finish_d;
    clear_go    = CLEAR & (state == ST_IDLE) & (count == '0) & !pending;
    done_line   = pending & (count == '0) & !MEM_WE & (state != ST_CLEAR);
    sweep_last  = (state == ST_CLEAR) & retire & (MEM_ADDR == 16'hFFFF);
    sweep_issue = (state == ST_CLEAR) & !sweep_last & EN & (!MEM_WE | MEM_ACK);

    count_next = count;
    if (push && !pop)
      count_next = count + (PW+1)'(1);
    else if (!push && pop)
      count_next = count - (PW+1)'(1);

    we_next = MEM_WE;
    if (state == ST_CLEAR) begin
      if (sweep_issue)
        we_next = 1'b1;
      else if (retire)
        we_next = 1'b0;
    end else if (pop) begin
      we_next = 1'b1;
    end else if (retire) begin
      we_next = 1'b0;
    end

    state_next = state;
    if (state == ST_CLEAR)
      state_next = sweep_last ? ST_IDLE : ST_CLEAR;
    else if (clear_go)
      state_next = ST_CLEAR;
    else if ((count_next != '0) || we_next)
      state_next = ST_DRAIN;
    else
      state_next = ST_IDLE;

    // Ready is registered from next-cycle occupancy so an accepted pixel always has room.
    ready_next = EN & (count_next != FULL_COUNT) & (state_next != ST_CLEAR);
  end

  always_ff @(posedge ACLK) begin
    if (push)
      fifo_mem[wr_ptr] <= {PIX_Y, PIX_X, COLOR};
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state     <= ST_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      finish_d  <= 1'b0;
      pending   <= 1'b0;
      clr_first <= 1'b0;
      PIX_READY <= 1'b0;
      MEM_ADDR  <= '0;
      MEM_DATA  <= '0;
      MEM_WE    <= 1'b0;
      DONE      <= 1'b0;
      OVF       <= 1'b0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      MEM_WE    <= we_next;
      PIX_READY <= ready_next;
      finish_d  <= LINE_FINISH;
      pending   <= (pending & !done_line) | finish_rise;
      DONE      <= done_line | sweep_last;
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      if (PIX_VALID && !PIX_READY)
        OVF <= 1'b1;
      if (clear_go)
        clr_first <= 1'b1;

      // The sweep reuses MEM_ADDR as its cursor; a paused sweep resumes at the next address.
      if (sweep_issue) begin
        MEM_ADDR  <= clr_first ? 16'h0000 : MEM_ADDR + 16'h0001;
        MEM_DATA  <= CLEAR_COLOR;
        clr_first <= 1'b0;
      end else if (pop) begin
        {MEM_ADDR, MEM_DATA} <= fifo_mem[rd_ptr];
      end
    end
  end

  assign BUSY = (count != '0) | MEM_WE | (state == ST_CLEAR);

endmodule

// File: tb/tb_line_pixel_writer.sv
// Directed plus randomized bench for line_pixel_writer; a negedge monitor scores every
// retired write against a queue of accepted pixels or the expected clear address.
module tb_line_pixel_writer;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        EN = 1'b0;
  logic        PIX_VALID = 1'b0;
  logic [7:0]  PIX_X = '0;
  logic [7:0]  PIX_Y = '0;
  logic        LINE_FINISH = 1'b0;
  logic [7:0]  COLOR = '0;
  logic        PIX_READY;
  logic        CLEAR = 1'b0;
  logic [15:0] MEM_ADDR;
  logic [7:0]  MEM_DATA;
  logic        MEM_WE;
  logic        MEM_ACK = 1'b0;
  logic        BUSY;
  logic        DONE;
  logic        OVF;

  line_pixel_writer dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .EN(EN), .PIX_VALID(PIX_VALID),
    .PIX_X(PIX_X), .PIX_Y(PIX_Y), .LINE_FINISH(LINE_FINISH), .COLOR(COLOR),
    .PIX_READY(PIX_READY), .CLEAR(CLEAR), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA),
    .MEM_WE(MEM_WE), .MEM_ACK(MEM_ACK), .BUSY(BUSY), .DONE(DONE), .OVF(OVF)
  );

  always #5 ACLK = ~ACLK;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [23:0] exp_q[$];
  logic        in_clear = 1'b0;
  int          clr_idx = 0;
  logic        ready_in_clear = 1'b0;
  logic        ovf_model = 1'b0;
  int          done_cnt = 0;
  int          extra_writes = 0;
  logic        prev_we = 1'b0;
  logic        prev_ack = 1'b0;
  logic [23:0] prev_ad = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 200 && BUSY !== 1'b0; i++) tick();
    check({tag, "_busy"}, BUSY, 0);
    check({tag, "_queue_left"}, exp_q.size(), 0);
    check({tag, "_extra_writes"}, extra_writes, 0);
  endtask

  // Inputs change 1ns after posedge, so at negedge they show what the next edge will sample.
  always @(negedge ACLK) begin
    if (!ARESETn) begin
      prev_we   = 1'b0;
      ovf_model = 1'b0;
    end else begin
      if (PIX_VALID && PIX_READY) exp_q.push_back({PIX_Y, PIX_X, COLOR});
      if (PIX_VALID && !PIX_READY) ovf_model = 1'b1;
      if (in_clear && PIX_READY) ready_in_clear = 1'b1;
      if (DONE) done_cnt++;
      if (prev_we && !prev_ack) begin
        check("hold_we", MEM_WE, 1);
        check("hold_addr_data", {MEM_ADDR, MEM_DATA}, prev_ad);
      end
      if (MEM_WE && MEM_ACK) begin
        if (in_clear) begin
          check("clear_write", {MEM_ADDR, MEM_DATA}, {clr_idx[15:0], 8'h00});
          clr_idx++;
        end else if (exp_q.size() == 0) begin
          extra_writes++;
        end else begin
          logic [23:0] ad;
          ad = exp_q.pop_front();
          check("pixel_write", {MEM_ADDR, MEM_DATA}, ad);
        end
      end
      prev_we  = MEM_WE;
      prev_ack = MEM_ACK;
      prev_ad  = {MEM_ADDR, MEM_DATA};
    end
  end

  initial begin
    int d0;
    EN = 1'b1;
    repeat (3) @(posedge ACLK);
    #1;
    check("rst_ready", PIX_READY, 0);
    check("rst_we", MEM_WE, 0);
    check("rst_addr", MEM_ADDR, 0);
    check("rst_data", MEM_DATA, 0);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_ovf", OVF, 0);
    ARESETn = 1'b1;
    tick();
    check("ready_after_release", PIX_READY, 1);

    // Three pixels with ack tied high, then a finish strobe.
    MEM_ACK = 1'b1; COLOR = 8'h2A;
    PIX_X = 8'd3; PIX_Y = 8'd5; PIX_VALID = 1'b1;
    tick();
    check("t1_first_edge_we", MEM_WE, 0);
    PIX_X = 8'd4;
    tick();
    check("t1_w0", {MEM_WE, MEM_ADDR, MEM_DATA}, {1'b1, 16'h0503, 8'h2A});
    PIX_X = 8'd5; PIX_Y = 8'd6;
    tick();
    check("t1_w1", {MEM_WE, MEM_ADDR, MEM_DATA}, {1'b1, 16'h0504, 8'h2A});
    PIX_VALID = 1'b0; LINE_FINISH = 1'b1;
    tick();
    check("t1_w2", {MEM_WE, MEM_ADDR, MEM_DATA}, {1'b1, 16'h0605, 8'h2A});
    LINE_FINISH = 1'b0;
    tick();
    check("t1_we_done_low", {MEM_WE, DONE}, 2'b00);
    tick();
    check("t1_done_pulse", DONE, 1);
    tick();
    check("t1_done_one_cycle", DONE, 0);
    check("t1_done_count", done_cnt, 1);
    wait_drain("t1");

    // Ack held low: first write must hold, FIFO fills, next pixel overflows.
    MEM_ACK = 1'b0;
    for (int i = 0; i < 9; i++) begin
      PIX_X = 8'(8'h10 + i); PIX_Y = 8'h20; COLOR = 8'(i); PIX_VALID = 1'b1;
      tick();
    end
    check("t2_ready_full", PIX_READY, 0);
    check("t2_held_write", {MEM_WE, MEM_ADDR, MEM_DATA}, {1'b1, 16'h2010, 8'h00});
    PIX_X = 8'h99; COLOR = 8'hEE;
    tick();
    PIX_VALID = 1'b0;
    check("t2_ovf", OVF, 1);
    check("t2_ovf_model", OVF, ovf_model);
    MEM_ACK = 1'b1;
    wait_drain("t2");

    // Push and pop on the same edge with four entries queued.
    MEM_ACK = 1'b0;
    for (int i = 0; i < 5; i++) begin
      PIX_X = 8'(8'h30 + i); PIX_Y = 8'h31; COLOR = 8'(8'h80 + i); PIX_VALID = 1'b1;
      tick();
    end
    check("t3_count_before", dut.count, 4);
    MEM_ACK = 1'b1; PIX_X = 8'h3F; COLOR = 8'h8F;
    tick();
    MEM_ACK = 1'b0; PIX_VALID = 1'b0;
    check("t3_count_same", dut.count, 4);
    MEM_ACK = 1'b1;
    wait_drain("t3");

    // Full-screen clear.
    CLEAR = 1'b1;
    tick();
    CLEAR = 1'b0; in_clear = 1'b1; clr_idx = 0;
    check("t4_ready_low", PIX_READY, 0);
    check("t4_busy", BUSY, 1);
    for (int i = 0; i < 70000 && DONE !== 1'b1; i++) tick();
    in_clear = 1'b0;
    check("t4_done", DONE, 1);
    check("t4_write_count", clr_idx, 65536);
    check("t4_final_addr", MEM_ADDR, 16'hFFFF);
    check("t4_final_we", MEM_WE, 0);
    check("t4_ready_seen", ready_in_clear, 0);
    tick();
    check("t4_done_count", done_cnt, 2);
    check("t4_ready_back", PIX_READY, 1);

    // Clear requested with two pixels queued is ignored.
    MEM_ACK = 1'b0;
    for (int i = 0; i < 3; i++) begin
      PIX_X = 8'(8'h50 + i); PIX_Y = 8'h51; COLOR = 8'(8'hC0 + i); PIX_VALID = 1'b1;
      tick();
    end
    PIX_VALID = 1'b0; CLEAR = 1'b1;
    tick();
    CLEAR = 1'b0; MEM_ACK = 1'b1;
    wait_drain("t5");
    repeat (3) tick();
    check("t5_no_clear_we", MEM_WE, 0);
    check("t5_ready", PIX_READY, 1);
    check("t5_extra", extra_writes, 0);

    // Reset in the middle of a drain with a finish pending.
    MEM_ACK = 1'b0;
    for (int i = 0; i < 4; i++) begin
      PIX_X = 8'(8'h40 + i); PIX_Y = 8'h77; COLOR = 8'h11; PIX_VALID = 1'b1;
      tick();
    end
    PIX_VALID = 1'b0; LINE_FINISH = 1'b1;
    tick();
    LINE_FINISH = 1'b0;
    tick();
    d0 = done_cnt;
    ARESETn = 1'b0;
    #1;
    check("t6_we_in_reset", MEM_WE, 0);
    check("t6_busy_in_reset", BUSY, 0);
    exp_q.delete();
    repeat (2) tick();
    ARESETn = 1'b1; MEM_ACK = 1'b1;
    repeat (5) tick();
    check("t6_no_done", done_cnt, d0);
    check("t6_busy_after", BUSY, 0);
    check("t6_ovf_cleared", OVF, 0);
    PIX_X = 8'h12; PIX_Y = 8'h34; COLOR = 8'h5A; PIX_VALID = 1'b1;
    tick();
    PIX_VALID = 1'b0;
    tick();
    check("t6_write_after", {MEM_WE, MEM_ADDR, MEM_DATA}, {1'b1, 16'h3412, 8'h5A});
    wait_drain("t6");

    // Random traffic with ack stalls and enable gaps.
    d0 = done_cnt;
    for (int i = 0; i < 1500; i++) begin
      PIX_VALID = 1'($urandom_range(0, 1));
      PIX_X = 8'($urandom);
      PIX_Y = 8'($urandom);
      COLOR = 8'($urandom);
      MEM_ACK = 1'($urandom_range(0, 1));
      EN = ($urandom_range(0, 7) != 0);
      tick();
    end
    PIX_VALID = 1'b0; EN = 1'b1; MEM_ACK = 1'b1;
    wait_drain("rand");
    check("rand_ovf", OVF, ovf_model);
    check("rand_no_done", done_cnt, d0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
